// File: rtl/vga_timing_pkg.sv
// Shared raster timing types, the 640x480@60 mode and total-length helpers.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } timing_mode_t;

    localparam timing_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        hs_pol:   1'b0, vs_pol: 1'b0
    };

    function automatic int unsigned h_total(input timing_mode_t m);
        return m.h_active + m.h_fp + m.h_sync + m.h_bp;
    endfunction

    function automatic int unsigned v_total(input timing_mode_t m);
        return m.v_active + m.v_fp + m.v_sync + m.v_bp;
    endfunction

    typedef enum logic {
        IDLE,
        RUN
    } vga_state_t;

endpackage

// File: rtl/video_sync_delay.sv
// Resettable shift register that realigns sync/DE with a pipelined pixel path.
module video_sync_delay #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_sr
            logic [WIDTH-1:0] sr [DEPTH];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with IDLE/RUN start-up, strobes,
// frame counter and a delayed sync/DE copy for the registered RGB path.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = MODE_640X480_60.h_active,
    parameter int   H_FP        = MODE_640X480_60.h_fp,
    parameter int   H_SYNC      = MODE_640X480_60.h_sync,
    parameter int   H_BP        = MODE_640X480_60.h_bp,
    parameter int   V_ACTIVE    = MODE_640X480_60.v_active,
    parameter int   V_FP        = MODE_640X480_60.v_fp,
    parameter int   V_SYNC      = MODE_640X480_60.v_sync,
    parameter int   V_BP        = MODE_640X480_60.v_bp,
    parameter logic HS_POL      = MODE_640X480_60.hs_pol,
    parameter logic VS_POL      = MODE_640X480_60.vs_pol,
    parameter int   CW          = 10,
    parameter int   FC_W        = 16,
    parameter int   PIPE_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    output logic [CW-1:0]   draw_x,
    output logic [CW-1:0]   draw_y,
    output logic            hsync,
    output logic            vsync,
    output logic            vde,
    output logic            hsync_d,
    output logic            vsync_d,
    output logic            vde_d,
    output logic            line_start,
    output logic            frame_start,
    output logic            vblank_start,
    output logic [FC_W-1:0] frame_count
);

    localparam timing_mode_t MODE = '{
        h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP,
        hs_pol:   HS_POL,   vs_pol: VS_POL
    };
    localparam int unsigned H_TOTAL = h_total(MODE);
    localparam int unsigned V_TOTAL = v_total(MODE);

    generate
        if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_cw
            $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    // One extra bit so bounds equal to 2**CW still compare correctly.
    localparam logic [CW:0]   HA     = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   VA     = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0]   VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    vga_state_t    state, state_nxt;
    logic [CW-1:0] x_nxt, y_nxt;
    logic [CW:0]   xe, ye;
    logic          run_nxt;
    logic          hs_nxt, vs_nxt, de_nxt;
    logic          ls_nxt, fs_nxt, vb_nxt;

    assign xe = {1'b0, x_nxt};
    assign ye = {1'b0, y_nxt};

    always_comb begin
        state_nxt = enable ? RUN : IDLE;
        x_nxt     = '0;
        y_nxt     = '0;
        if (enable && state == RUN) begin
            if (draw_x == H_LAST) begin
                x_nxt = '0;
                y_nxt = (draw_y == V_LAST) ? '0 : draw_y + 1'b1;
            end else begin
                x_nxt = draw_x + 1'b1;
                y_nxt = draw_y;
            end
        end
        run_nxt = (state_nxt == RUN);
        de_nxt  = run_nxt && (xe < HA) && (ye < VA);
        hs_nxt  = (run_nxt && xe >= HS_BEG && xe < HS_END) ? HS_POL : ~HS_POL;
        vs_nxt  = (run_nxt && ye >= VS_BEG && ye < VS_END) ? VS_POL : ~VS_POL;
        ls_nxt  = run_nxt && (x_nxt == '0);
        fs_nxt  = ls_nxt && (y_nxt == '0);
        vb_nxt  = ls_nxt && (ye == VA);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            draw_x       <= '0;
            draw_y       <= '0;
            hsync        <= ~HS_POL;
            vsync        <= ~VS_POL;
            vde          <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            state        <= state_nxt;
            draw_x       <= x_nxt;
            draw_y       <= y_nxt;
            hsync        <= hs_nxt;
            vsync        <= vs_nxt;
            vde          <= de_nxt;
            line_start   <= ls_nxt;
            frame_start  <= fs_nxt;
            vblank_start <= vb_nxt;
            if (fs_nxt) frame_count <= frame_count + 1'b1;
        end
    end

    video_sync_delay #(
        .DEPTH   (PIPE_STAGES),
        .WIDTH   (3),
        .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
    ) u_sync_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({hsync, vsync, vde}),
        .dout    ({hsync_d, vsync_d, vde_d})
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default mode start/lines, small mode frames, abort,
// re-enable, delay alignment and asynchronous reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_def, en_def, rst_sm, en_sm;

    logic [9:0]  d_x, d_y;
    logic        d_hs, d_vs, d_de, d_hsd, d_vsd, d_ded, d_ls, d_fs, d_vb;
    logic [15:0] d_fc;

    logic [3:0]  s_x, s_y;
    logic        s_hs, s_vs, s_de, s_hsd, s_vsd, s_ded, s_ls, s_fs, s_vb;
    logic [1:0]  s_fc;

    logic [3:0]  z_x, z_y;
    logic        z_hs, z_vs, z_de, z_hsd, z_vsd, z_ded, z_ls, z_fs, z_vb;
    logic [15:0] z_fc;

    vga_timing_gen u_def (
        .clk(clk), .reset_n(rst_def), .enable(en_def),
        .draw_x(d_x), .draw_y(d_y),
        .hsync(d_hs), .vsync(d_vs), .vde(d_de),
        .hsync_d(d_hsd), .vsync_d(d_vsd), .vde_d(d_ded),
        .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb),
        .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .CW(4), .FC_W(2), .PIPE_STAGES(3)
    ) u_sm (
        .clk(clk), .reset_n(rst_sm), .enable(en_sm),
        .draw_x(s_x), .draw_y(s_y),
        .hsync(s_hs), .vsync(s_vs), .vde(s_de),
        .hsync_d(s_hsd), .vsync_d(s_vsd), .vde_d(s_ded),
        .line_start(s_ls), .frame_start(s_fs), .vblank_start(s_vb),
        .frame_count(s_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .CW(4), .PIPE_STAGES(0)
    ) u_p0 (
        .clk(clk), .reset_n(rst_sm), .enable(en_sm),
        .draw_x(z_x), .draw_y(z_y),
        .hsync(z_hs), .vsync(z_vs), .vde(z_de),
        .hsync_d(z_hsd), .vsync_d(z_vsd), .vde_d(z_ded),
        .line_start(z_ls), .frame_start(z_fs), .vblank_start(z_vb),
        .frame_count(z_fc)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // {hsync, vsync, vde} references for the two modes
    function automatic logic [2:0] df_ref(input int x, input int y);
        return {!(x >= 656 && x < 752), !(y >= 490 && y < 492),
                (x < 640 && y < 480)};
    endfunction

    function automatic logic [2:0] sm_ref(input int x, input int y);
        return {(x >= 10 && x < 12), (y == 5), (x < 8 && y < 4)};
    endfunction

    initial begin
        int bad_xy, bad_sig, bad_d, bad_str, bad_z;
        int hs_cnt, de_cnt, fs_cnt, ex, ey;
        logic [2:0] r, rd;
        int fcs [5];
        int fc_exp [5];

        fc_exp = '{1, 2, 3, 0, 1};
        rst_def = 1'b0; en_def = 1'b0;
        rst_sm  = 1'b0; en_sm  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_x", int'(d_x), 0);
        chk("rst_hs", int'(d_hs), 1);
        chk("rst_de", int'(d_de), 0);
        chk("rst_fc", int'(d_fc), 0);
        chk("rst_hsd", int'(d_hsd), 1);

        rst_def = 1'b1; rst_sm = 1'b1;
        @(negedge clk);
        chk("idle_vs", int'(d_vs), 1);
        chk("idle_fs", int'(d_fs), 0);
        chk("idle_sm_hs", int'(s_hs), 0);

        en_def = 1'b1;
        @(negedge clk);
        chk("first_x", int'(d_x), 0);
        chk("first_y", int'(d_y), 0);
        chk("first_fs", int'(d_fs), 1);
        chk("first_ls", int'(d_ls), 1);
        chk("first_de", int'(d_de), 1);
        chk("first_fc", int'(d_fc), 1);

        bad_xy = 0; bad_sig = 0; bad_d = 0; bad_str = 0;
        hs_cnt = 0; de_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            ex = i % 800;
            ey = i / 800;
            r  = df_ref(ex, ey);
            rd = (i >= 2) ? df_ref((i-2) % 800, (i-2) / 800) : 3'b110;
            if (int'(d_x) != ex || int'(d_y) != ey) bad_xy++;
            if ({d_hs, d_vs, d_de} !== r) bad_sig++;
            if ({d_hsd, d_vsd, d_ded} !== rd) bad_d++;
            if (d_ls !== (ex == 0) || d_fs !== (i == 0) || d_vb !== 1'b0)
                bad_str++;
            if (!d_hs) hs_cnt++;
            if (d_de) de_cnt++;
            @(negedge clk);
        end
        chk("def_xy", bad_xy, 0);
        chk("def_sig", bad_sig, 0);
        chk("def_dly2", bad_d, 0);
        chk("def_strobe", bad_str, 0);
        chk("def_hs_cnt", hs_cnt, 192);
        chk("def_de_cnt", de_cnt, 1280);
        chk("def_line2_y", int'(d_y), 2);
        en_def = 1'b0;
        @(negedge clk);
        chk("def_stop_de", int'(d_de), 0);

        en_sm = 1'b1;
        @(negedge clk);
        bad_xy = 0; bad_sig = 0; bad_d = 0; bad_str = 0; bad_z = 0;
        fs_cnt = 0;
        for (int i = 0; i < 640; i++) begin
            ex = i % 16;
            ey = (i / 16) % 8;
            r  = sm_ref(ex, ey);
            rd = (i >= 3) ? sm_ref((i-3) % 16, ((i-3) / 16) % 8) : 3'b000;
            if (int'(s_x) != ex || int'(s_y) != ey) bad_xy++;
            if ({s_hs, s_vs, s_de} !== r) bad_sig++;
            if ({s_hsd, s_vsd, s_ded} !== rd) bad_d++;
            if (s_ls !== (ex == 0) || s_fs !== (ex == 0 && ey == 0) ||
                s_vb !== (ex == 0 && ey == 4)) bad_str++;
            if ({z_hs, z_vs, z_de} !== {~r[2], ~r[1], r[0]} ||
                {z_hsd, z_vsd, z_ded} !== {~r[2], ~r[1], r[0]}) bad_z++;
            if (s_fs) begin
                if (fs_cnt < 5) fcs[fs_cnt] = int'(s_fc);
                fs_cnt++;
            end
            @(negedge clk);
        end
        chk("sm_xy", bad_xy, 0);
        chk("sm_sig", bad_sig, 0);
        chk("sm_dly3", bad_d, 0);
        chk("sm_strobe", bad_str, 0);
        chk("p0_dly0", bad_z, 0);
        chk("sm_frames", fs_cnt, 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("sm_fc%0d", k), (k < fs_cnt) ? fcs[k] : -1,
                fc_exp[k]);
        chk("sm_fc_wrap", int'(s_fc), 2);

        repeat (37) @(negedge clk);
        chk("abort_at_x", int'(s_x), 5);
        chk("abort_at_y", int'(s_y), 2);
        en_sm = 1'b0;
        @(negedge clk);
        chk("abort_x", int'(s_x), 0);
        chk("abort_y", int'(s_y), 0);
        chk("abort_de", int'(s_de), 0);
        chk("abort_hs", int'(s_hs), 0);
        chk("abort_vs", int'(s_vs), 0);
        chk("abort_fs", int'(s_fs), 0);
        chk("abort_ded_old", int'(s_ded), 1);
        repeat (3) @(negedge clk);
        chk("abort_ded_flush", int'(s_ded), 0);

        en_sm = 1'b1;
        @(negedge clk);
        chk("reen_fs", int'(s_fs), 1);
        chk("reen_x", int'(s_x), 0);
        chk("reen_de", int'(s_de), 1);
        chk("reen_fc", int'(s_fc), 3);

        repeat (10) @(negedge clk);
        chk("pre_rst_hs", int'(s_hs), 1);
        chk("pre_rst_ded", int'(s_ded), 1);
        #5 rst_sm = 1'b0;
        #1;
        chk("arst_x", int'(s_x), 0);
        chk("arst_hs", int'(s_hs), 0);
        chk("arst_ls", int'(s_ls), 0);
        chk("arst_fc", int'(s_fc), 0);
        chk("arst_ded", int'(s_ded), 0);
        chk("arst_p0_hsd", int'(z_hsd), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator. Replaces the fixed 640x480 counter logic in the top level.
- Provides configurable active area, porches, sync widths and sync polarities.
- Adds an explicit IDLE/RUN start-up sequence, line/frame/vblank strobes and a frame counter.
- Provides a sync/DE copy delayed by PIPE_STAGES so that HDMI control signals align with the sprite engine's registered RGB.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CW, 10, draw_x/draw_y width; elaboration error if H_TOTAL or V_TOTAL > 2**CW
- FC_W, 16, frame_count width
- PIPE_STAGES, 2, extra delay of the *_d outputs (0 allowed)

Ports:
- clk  in  1  pixel clock (25 MHz at defaults)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run request (system_ready); synchronous
- draw_x  out  CW  current pixel column
- draw_y  out  CW  current line
- hsync  out  1  horizontal sync, aligned with draw_x/draw_y
- vsync  out  1  vertical sync, aligned
- vde  out  1  active-video flag, aligned
- hsync_d  out  1  hsync delayed PIPE_STAGES cycles
- vsync_d  out  1  vsync delayed PIPE_STAGES cycles
- vde_d  out  1  vde delayed PIPE_STAGES cycles
- line_start  out  1  one-cycle pulse when draw_x==0 during RUN
- frame_start  out  1  one-cycle pulse when (draw_x,draw_y)==(0,0) during RUN
- vblank_start  out  1  one-cycle pulse when draw_x==0 and draw_y==V_ACTIVE
- frame_count  out  FC_W  completed-frame-start count, wraps modulo 2**FC_W

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
- All outputs are registered. The non-_d outputs are mutually aligned and describe the same (x,y) in the same cycle.
- Reset (reset_n low, asynchronous):
  - state = IDLE; draw_x = draw_y = 0
  - hsync = ~HS_POL; vsync = ~VS_POL; vde = 0
  - all strobes = 0; frame_count = 0
  - whole delay line = inactive values
- FSM states IDLE and RUN:
  - IDLE: outputs held at the reset values. When enable = 1 at a clock edge → RUN, presenting (0,0) with frame_start = line_start = 1, vde = 1, and frame_count incremented.
  - RUN: each edge, x advances. At x = H_TOTAL-1, x wraps to 0 and y advances. At y = V_TOTAL-1 together with the x wrap, y wraps to 0.
  - RUN with enable = 0 at an edge → IDLE immediately, with reset-value outputs on the next cycle (mid-frame abort, no completion of the line).
- Decode, per presented (x,y):
  - vde = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hsync = HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults), else ~HS_POL
  - vsync = VS_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (lines 490..491), else ~VS_POL
  - vsync changes at x = 0 of the line, not mid-line
- frame_count increments in the same cycle that frame_start is presented; it wraps without saturation.
- Delay line: the *_d outputs equal the non-_d outputs PIPE_STAGES cycles earlier. With PIPE_STAGES = 0 they are identical. The delay line is cleared only by reset_n, not by an enable drop, so it flushes naturally to inactive values.
- enable and the x wrap may coincide. enable = 0 always wins.

Decomposition:
- Package vga_timing_pkg holds:
  - the timing_mode_t struct (active, fp, sync, bp per axis, and polarities)
  - localparams for the 640x480@60 mode
  - a function returning H_TOTAL/V_TOTAL
  - the state enum {IDLE, RUN}
- One sub-module, video_sync_delay: parametrised shift register (DEPTH, WIDTH, reset value), async active-low reset, used for the 3-bit {hsync, vsync, vde} delay.

Test Plan:
- Defaults, enable held high:
  - frame_start period = 420000 cycles
  - vde high for exactly 307200 cycles/frame
  - hsync low exactly for x = 656..751 on every line
  - vsync low exactly for lines 490..491
- First enable edge after reset → next cycle shows draw_x = 0, draw_y = 0, frame_start = 1, vde = 1, frame_count = 1. No pixel (0,0) is skipped.
- Drop enable while presenting (300,200) → next cycle shows draw_x = draw_y = 0, vde = 0, syncs inactive. Re-enable → frame_start = 1 again at (0,0).
- Small mode (H = 8/2/2/4, V = 4/1/1/2, HS_POL = VS_POL = 1):
  - hsync high only at x = 10..11
  - vsync high only on y = 5
  - vblank_start at (0,4)
  - frame period = 128 cycles
- FC_W = 2: five frames → frame_count sequence 1, 2, 3, 0, 1.
- PIPE_STAGES = 3 → hsync_d/vsync_d/vde_d equal the undelayed signals shifted by exactly 3 cycles. Assert reset_n low mid-line → all outputs, including *_d, are inactive within the same cycle (asynchronous).
